// File: rtl/m_wbtrace_tx.sv
// Writeback trace transmitter: buffers 32-bit writeback values in a FIFO and
// prints each one on a UART TX line as "%08x\n" (8N1, LSB first, idle high).
module m_wbtrace_tx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_LOG2    = 4
) (
    input  logic        w_clk,
    input  logic        w_rst,
    input  logic        w_valid,
    input  logic [31:0] w_data,
    output logic        r_txd,
    output logic        w_busy,
    output logic        r_ovf,
    output logic [15:0] r_drop
);

    localparam int DEPTH = 1 << FIFO_LOG2;
    localparam int PTR_W = FIFO_LOG2 + 1;
    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    logic [31:0]      r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic             w_empty;
    logic             w_full;
    logic             w_pop;
    logic             w_push;
    logic             w_drop_ev;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bit;
    logic [3:0]       r_char;
    logic [31:0]      r_word;
    logic             w_bit_end;
    logic [3:0]       w_nib;
    logic [7:0]       w_chr;

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[FIFO_LOG2] != r_rptr[FIFO_LOG2]) &&
                     (r_wptr[FIFO_LOG2-1:0] == r_rptr[FIFO_LOG2-1:0]);

    // A pop frees a slot at the same edge, so a push into a full FIFO is kept.
    assign w_pop     = (r_state == IDLE) && !w_empty;
    assign w_push    = w_valid && (!w_full || w_pop);
    assign w_drop_ev = w_valid && w_full && !w_pop;
    assign w_busy    = !w_empty || (r_state != IDLE);

    assign w_bit_end = (r_cnt == CNT_LAST);

    // NOTE: every always_comb output gets a value on every path, otherwise a latch is inferred.
    always_comb begin
        w_nib = r_word[{~r_char[2:0], 2'b00} +: 4];
        if (r_char[3])
            w_chr = 8'h0a;
        else if (w_nib < 4'd10)
            w_chr = 8'h30 + {4'h0, w_nib};
        else
            w_chr = 8'h57 + {4'h0, w_nib};
    end

    // NOTE: storage arrays carry no reset; the pointers alone define what is valid.
    always_ff @(posedge w_clk) begin
        if (w_push)
            r_mem[r_wptr[FIFO_LOG2-1:0]] <= w_data;
        if (w_pop)
            r_word <= r_mem[r_rptr[FIFO_LOG2-1:0]];
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_ovf  <= 1'b0;
            r_drop <= '0;
        end else begin
            if (w_push)
                r_wptr <= r_wptr + PTR_W'(1);
            if (w_pop)
                r_rptr <= r_rptr + PTR_W'(1);
            if (w_drop_ev) begin
                r_ovf <= 1'b1;
                if (r_drop != 16'hffff)
                    r_drop <= r_drop + 16'd1;
            end
        end
    end

    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_char  <= '0;
            r_txd   <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    r_txd <= 1'b1;
                    if (w_pop) begin
                        r_char  <= '0;
                        r_cnt   <= '0;
                        r_txd   <= 1'b0;
                        r_state <= START;
                    end
                end
                START: begin
                    if (w_bit_end) begin
                        r_cnt   <= '0;
                        r_bit   <= '0;
                        r_txd   <= w_chr[0];
                        r_state <= DATA;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (w_bit_end) begin
                        r_cnt <= '0;
                        if (r_bit == 3'd7) begin
                            r_txd   <= 1'b1;
                            r_state <= STOP;
                        end else begin
                            r_bit <= r_bit + 3'd1;
                            r_txd <= w_chr[r_bit + 3'd1];
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                STOP: begin
                    if (w_bit_end) begin
                        r_cnt <= '0;
                        // Character 8 is the trailing LF; after it the word is done.
                        if (r_char == 4'd8) begin
                            r_txd   <= 1'b1;
                            r_state <= IDLE;
                        end else begin
                            r_char  <= r_char + 4'd1;
                            r_txd   <= 1'b0;
                            r_state <= START;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_m_wbtrace_tx.sv
// Bench for m_wbtrace_tx: a "%08x\n" reference model with a FIFO occupancy
// model, plus a UART receiver that decodes the TX line mid-bit.
module tb_m_wbtrace_tx;

    localparam int CPB      = 4;
    localparam int FLOG     = 4;
    localparam int DEPTH    = 16;
    localparam int WORD_CYC = 9 * 10 * CPB;

    typedef logic [7:0] u8_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid = 1'b0;
    logic [31:0] data = '0;
    logic        txd;
    logic        busy;
    logic        ovf;
    logic [15:0] drop;

    int n_checks = 0;
    int n_fail   = 0;

    m_wbtrace_tx #(.CLKS_PER_BIT(CPB), .FIFO_LOG2(FLOG)) dut (
        .w_clk  (clk),
        .w_rst  (rst),
        .w_valid(valid),
        .w_data (data),
        .r_txd  (txd),
        .w_busy (busy),
        .r_ovf  (ovf),
        .r_drop (drop)
    );

    always #5 clk = ~clk;

    // Reference model: queue of waiting words, transmitter free again one
    // cycle after a full 9-character frame.
    longint      edge_n = 0;
    longint      free_at = 0;
    logic [31:0] m_q[$];
    int          m_drop = 0;
    bit          m_ovf = 1'b0;
    u8_t         exp_bytes[$];

    always @(posedge clk) begin
        string       s;
        bit          do_pop;
        bit          full;
        logic [31:0] w;
        edge_n++;
        if (rst) begin
            m_q.delete();
            exp_bytes.delete();
            m_drop  = 0;
            m_ovf   = 1'b0;
            free_at = 0;
        end else begin
            do_pop = (m_q.size() != 0) && (edge_n >= free_at);
            full   = (m_q.size() == DEPTH);
            if (do_pop) begin
                w = m_q.pop_front();
                s = $sformatf("%08x\n", w);
                for (int i = 0; i < s.len(); i++) exp_bytes.push_back(u8_t'(s[i]));
                free_at = edge_n + WORD_CYC + 1;
            end
            if (valid) begin
                if (!full || do_pop) m_q.push_back(data);
                else begin
                    m_ovf = 1'b1;
                    if (m_drop < 65535) m_drop++;
                end
            end
        end
    end

    // UART receiver sampling on the falling clock edge.
    longint neg_n = 0;
    u8_t    rx_bytes[$];
    longint starts[$];
    int     rx_err = 0;
    bit     d_on = 1'b0;
    int     d_cnt = 0;
    u8_t    d_byte = '0;

    always @(negedge clk) begin
        neg_n++;
        if (rst) begin
            rx_bytes.delete();
            starts.delete();
            d_on = 1'b0;
        end else if (!d_on) begin
            if (txd === 1'b0) begin
                d_on  = 1'b1;
                d_cnt = 0;
                starts.push_back(neg_n);
            end
        end else begin
            d_cnt++;
            if (d_cnt == CPB / 2) begin
                if (txd !== 1'b0) rx_err++;
            end else if ((d_cnt % CPB) == CPB / 2 && d_cnt < 9 * CPB) begin
                d_byte[d_cnt / CPB - 1] = txd;
            end else if (d_cnt == 9 * CPB + CPB / 2) begin
                if (txd !== 1'b1) rx_err++;
                rx_bytes.push_back(d_byte);
                d_on = 1'b0;
            end
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    u8_t    want[$];
    longint e0_ovf = 0;

    function automatic void want_str(input string s);
        for (int i = 0; i < s.len(); i++) want.push_back(u8_t'(s[i]));
    endfunction

    function automatic int rx_vs_want();
        int bad = 0;
        if (rx_bytes.size() != want.size()) bad++;
        for (int i = 0; i < rx_bytes.size() && i < want.size(); i++)
            if (rx_bytes[i] !== want[i]) bad++;
        return bad;
    endfunction

    function automatic int rx_vs_model();
        int bad = 0;
        if (rx_bytes.size() != exp_bytes.size()) bad++;
        for (int i = 0; i < rx_bytes.size() && i < exp_bytes.size(); i++)
            if (rx_bytes[i] !== exp_bytes[i]) bad++;
        return bad;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst   = 1'b1;
        valid = 1'b0;
        repeat (n) tick();
        rst = 1'b0;
    endtask

    task automatic wait_drain(input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            if (busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        int bad = 0;
        do_reset(2);
        n_checks++;
        if (txd !== 1'b1) begin n_fail++; $display("FAIL reset_txd: got %b, expected 1", txd); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, expected 0", busy); end
        n_checks++;
        if (ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b, expected 0", ovf); end
        n_checks++;
        if (drop !== 16'd0) begin n_fail++; $display("FAIL reset_drop: got %0d, expected 0", drop); end
        for (int i = 0; i < 50; i++) begin
            tick();
            if (txd !== 1'b1 || busy !== 1'b0 || ovf !== 1'b0 || drop !== 16'd0) bad++;
        end
        n_checks++;
        if (bad !== 0) begin n_fail++; $display("FAIL reset_idle: %0d bad cycles, expected 0", bad); end
    endtask

    task automatic test_single();
        do_reset(2);
        repeat (3) tick();
        valid = 1'b1;
        data  = 32'h0000002a;
        tick();
        valid = 1'b0;
        n_checks++;
        if (txd !== 1'b1) begin n_fail++; $display("FAIL single_txd_E: got %b, expected 1", txd); end
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_E: got %b, expected 1", busy); end
        tick();
        n_checks++;
        if (txd !== 1'b0) begin n_fail++; $display("FAIL single_start_E1: got %b, expected 0", txd); end
        repeat (WORD_CYC - 1) tick();
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_last: got %b, expected 1", busy); end
        tick();
        n_checks++;
        if (busy !== 1'b0 || txd !== 1'b1) begin
            n_fail++; $display("FAIL single_done: busy=%b txd=%b, expected busy=0 txd=1", busy, txd);
        end
        want.delete();
        want_str("0000002a\n");
        n_checks++;
        if (rx_vs_want() !== 0) begin
            n_fail++; $display("FAIL single_bytes: %0d bytes received with %0d differences, expected 9 exact", rx_bytes.size(), rx_vs_want());
        end
        n_checks++;
        if (rx_vs_model() !== 0) begin n_fail++; $display("FAIL single_model: %0d differences, expected 0", rx_vs_model()); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int bad = 0;
        do_reset(2);
        valid = 1'b1;
        data  = 32'h89abcdef;
        tick();
        data = 32'h00000000;
        tick();
        valid = 1'b0;
        wait_drain(3000, ok);
        repeat (4) tick();
        n_checks++;
        if (ok !== 1'b1) begin n_fail++; $display("FAIL b2b_drain: busy still %b after bound, expected 0", busy); end
        want.delete();
        want_str("89abcdef\n00000000\n");
        n_checks++;
        if (rx_vs_want() !== 0) begin
            n_fail++; $display("FAIL b2b_bytes: %0d bytes, %0d differences, expected 18 exact", rx_bytes.size(), rx_vs_want());
        end
        n_checks++;
        if (starts.size() !== 18) begin n_fail++; $display("FAIL b2b_starts: got %0d start bits, expected 18", starts.size()); end
        for (int i = 1; i < starts.size(); i++)
            if (starts[i] - starts[i-1] != ((i == 9) ? 41 : 40)) bad++;
        n_checks++;
        if (bad !== 0) begin n_fail++; $display("FAIL b2b_spacing: %0d wrong character gaps, expected 0", bad); end
        n_checks++;
        if (rx_err !== 0) begin n_fail++; $display("FAIL b2b_framing: got %0d framing errors, expected 0", rx_err); end
    endtask

    task automatic test_overflow();
        int exp_d;
        do_reset(2);
        for (int i = 0; i < 20; i++) begin
            valid = 1'b1;
            data  = 32'(i);
            tick();
            if (i == 0) e0_ovf = edge_n;
            exp_d = (i >= 17) ? i - 16 : 0;
            n_checks++;
            if (drop !== 16'(exp_d)) begin
                n_fail++; $display("FAIL ovf_drop_step%0d: got %0d, expected %0d", i, drop, exp_d);
            end
        end
        valid = 1'b0;
        n_checks++;
        if (ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b, expected 1", ovf); end
    endtask

    task automatic test_full_push();
        bit ok;
        while (edge_n < e0_ovf + 360) tick();
        valid = 1'b1;
        data  = 32'ha5a50001;
        tick();
        n_checks++;
        if (drop !== 16'd4) begin n_fail++; $display("FAIL fullpush_drop_before: got %0d, expected 4", drop); end
        data = 32'ha5a50002;
        tick();
        valid = 1'b0;
        n_checks++;
        if (drop !== 16'd4) begin n_fail++; $display("FAIL fullpush_drop_at_pop: got %0d, expected 4", drop); end
        wait_drain(9000, ok);
        repeat (4) tick();
        n_checks++;
        if (ok !== 1'b1) begin n_fail++; $display("FAIL fullpush_drain: busy still %b after bound, expected 0", busy); end
        want.delete();
        for (int i = 0; i <= 16; i++) want_str($sformatf("%08x\n", i));
        want_str("a5a50002\n");
        n_checks++;
        if (rx_vs_want() !== 0) begin
            n_fail++; $display("FAIL fullpush_bytes: %0d bytes, %0d differences, expected %0d exact", rx_bytes.size(), rx_vs_want(), want.size());
        end
        n_checks++;
        if (ovf !== 1'b1 || drop !== 16'd4) begin
            n_fail++; $display("FAIL fullpush_sticky: ovf=%b drop=%0d, expected ovf=1 drop=4", ovf, drop);
        end
    endtask

    task automatic test_reset_mid_frame();
        bit ok;
        int lows = 0;
        do_reset(1);
        n_checks++;
        if (drop !== 16'd0 || ovf !== 1'b0) begin
            n_fail++; $display("FAIL midrst_clear: ovf=%b drop=%0d, expected 0 and 0", ovf, drop);
        end
        repeat (2) tick();
        for (int i = 0; i < 5; i++) begin
            valid = 1'b1;
            data  = $urandom;
            tick();
        end
        valid = 1'b0;
        repeat (90) tick();
        n_checks++;
        if (rx_bytes.size() !== 2 || busy !== 1'b1) begin
            n_fail++; $display("FAIL midrst_pre: %0d bytes busy=%b, expected 2 bytes busy=1", rx_bytes.size(), busy);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++;
        if (txd !== 1'b1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL midrst_after: txd=%b busy=%b, expected txd=1 busy=0", txd, busy);
        end
        for (int i = 0; i < 500; i++) begin
            tick();
            if (txd !== 1'b1 || busy !== 1'b0) lows++;
        end
        n_checks++;
        if (lows !== 0 || rx_bytes.size() !== 0) begin
            n_fail++; $display("FAIL midrst_quiet: %0d active cycles, %0d bytes, expected 0 and 0", lows, rx_bytes.size());
        end
        valid = 1'b1;
        data  = 32'hdeadbeef;
        tick();
        valid = 1'b0;
        wait_drain(1000, ok);
        repeat (4) tick();
        want.delete();
        want_str("deadbeef\n");
        n_checks++;
        if (ok !== 1'b1 || rx_vs_want() !== 0) begin
            n_fail++; $display("FAIL midrst_fresh: drained=%b, %0d differences, expected drained=1 and 0", ok, rx_vs_want());
        end
    endtask

    task automatic test_random();
        bit ok;
        int p;
        do_reset(2);
        for (int c = 0; c < 400; c++) begin
            p     = (c < 80) ? 70 : 4;
            valid = ($urandom_range(0, 99) < p);
            data  = $urandom;
            tick();
        end
        valid = 1'b0;
        wait_drain(25000, ok);
        repeat (4) tick();
        n_checks++;
        if (ok !== 1'b1) begin n_fail++; $display("FAIL rand_drain: busy still %b after bound, expected 0", busy); end
        n_checks++;
        if (rx_vs_model() !== 0) begin
            n_fail++; $display("FAIL rand_bytes: got %0d bytes, %0d differences vs %0d expected", rx_bytes.size(), rx_vs_model(), exp_bytes.size());
        end
        n_checks++;
        if (drop !== 16'(m_drop) || ovf !== m_ovf) begin
            n_fail++; $display("FAIL rand_drop: drop=%0d ovf=%b, expected drop=%0d ovf=%b", drop, ovf, m_drop, m_ovf);
        end
        n_checks++;
        if (rx_err !== 0) begin n_fail++; $display("FAIL rand_framing: got %0d framing errors, expected 0", rx_err); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_full_push();
        test_reset_mid_frame();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
